freq_phase_meter: RTL and testbench
===================================

Name: freq_phase_meter

Overview:
Parametrised gated frequency / duty / phase meter for the signal-measurement path. It measures reference input sig_in over GATE_PERIODS whole periods and reports the accumulated clock counts for period, high time and sig_in→sig_in1 rising-edge delay. Results go to the display/UART logic, which derives frequency, duty and phase by division. It succeeds the fixed single-purpose frequency counter and adds start/done handshaking, gate averaging, a timeout and saturation flags.

Parameters:
CNT_W, 32, width of every accumulator and result
GATE_PERIODS, 16, sig_in periods per measurement (≥1)
SYNC_STAGES, 2, input synchroniser depth (≥2)
TIMEOUT_CYCLES, 50_000_000, max clk cycles between sig_in rising edges before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sig_in  in  1  async reference signal
sig_in1  in  1  async second signal for phase
start  in  1  1-cycle request to begin a measurement
busy  out  1  measurement in progress
done  out  1  1-cycle pulse, results valid
timeout  out  1  last measurement aborted (no edge in time)
ovf  out  1  an accumulator saturated in last measurement
phase_miss  out  1  a sig_in period passed without a sig_in1 rising edge
period_cnt  out  CNT_W  clk cycles over GATE_PERIODS periods
high_cnt  out  CNT_W  clk cycles sig_in high in window
phase_cnt  out  CNT_W  summed sig_in-rise→sig_in1-rise cycles

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs, accumulators, synchronisers and flags 0. Reset mid-measurement aborts with no done pulse.
- Both inputs pass through SYNC_STAGES flops plus one edge-detect register. Pin-to-detect latency is SYNC_STAGES+1 cycles, identical for both inputs, so phase is unbiased.
- States: IDLE, ARM, MEAS, DONE.
- IDLE: start=1 → ARM. busy=1 from the next cycle. start is ignored while busy=1.
- ARM: waits for a sig_in rising-edge detect (arming edge). On that edge → MEAS. The window opens on the arming-edge cycle, inclusive.
- MEAS: counts sig_in rising edges after the arming edge. On the GATE_PERIODS-th edge → DONE. The window closes before that cycle (exclusive), so the window holds exactly GATE_PERIODS×period cycles.
- Accumulators, within the window only:
  - period acc +1 every cycle.
  - high acc +1 when synced sig_in=1.
  - phase acc +1 while phase_run=1.
- phase_run:
  - Set on a sig_in rise that lies inside the window, including the arming edge.
  - Cleared on a sig_in1 rise.
  - sig_in rise and sig_in1 rise in the same cycle → phase_run=0, contribution 0.
  - sig_in rise while phase_run=1 → phase_miss set, phase_run stays 1.
- Saturation: an accumulator at all-ones holds its value and sets ovf.
- Timeout counter:
  - Cleared on every sig_in rise and on leaving IDLE.
  - Runs in ARM and MEAS.
  - Reaching TIMEOUT_CYCLES → DONE with timeout=1, all result counts 0, flags 0.
- DONE (one cycle): result registers and flags update. done=1, busy=0 from the same cycle. Then → IDLE.
- Results hold until the next DONE. Accumulators clear on entering ARM.
- start asserted in the DONE cycle is ignored; it must be re-asserted in IDLE.

Test Plan:
1. Setup for cases 1–3, 5, 6: clk 50 MHz, GATE_PERIODS=4, SYNC_STAGES=2. sig_in high 60 ns / low 100 ns (8 clk period, 3 high). sig_in1 = sig_in delayed 40 ns. Pulse start → one done pulse with period_cnt=32, high_cnt=12, phase_cnt=8, timeout=0, ovf=0, phase_miss=0.
2. Same setup, sig_in1 edges aligned to sig_in → phase_cnt=0, phase_miss=0.
3. sig_in1 held constant 1 → phase_cnt=32, phase_miss=1.
4. sig_in held 0, TIMEOUT_CYCLES=1000, start → done exactly 1000 cycles after entering ARM; timeout=1, all counts 0.
5. CNT_W=4, case 1 stimulus → period_cnt=15, ovf=1.
6. rst_n low during MEAS, then case 1 rerun → no done during the aborted run; second run gives case 1 values; start pulses during busy produce no extra done.

Source files
------------

// File: rtl/freq_phase_meter.sv
// freq_phase_meter: gated period / high-time / phase-delay accumulator over GATE_PERIODS sig_in periods.
module freq_phase_meter #(
  parameter int CNT_W          = 32,
  parameter int GATE_PERIODS   = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             sig_in1,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             ovf,
  output logic             phase_miss,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] phase_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EW = $clog2(GATE_PERIODS + 1);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] s0_q, s0_d, s1_q, s1_d;
  logic                   e0_q, e0_d, e1_q, e1_d;
  logic [TW-1:0]          to_q, to_d;
  logic [EW-1:0]          ecnt_q, ecnt_d;
  logic                   run_q, run_d, miss_q, miss_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]       per_q, per_d, high_q, high_d, ph_q, ph_d;
  logic [CNT_W-1:0]       rper_q, rper_d, rhigh_q, rhigh_d, rph_q, rph_d;
  logic                   rtmo_q, rtmo_d, rovf_q, rovf_d, rmiss_q, rmiss_d;
  logic                   rise0, rise1, win, tmo, clear, to_hit, op, oh, oph;
  logic [CNT_W-1:0]       per_n, high_n, ph_n;

  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    sat_inc = {en & (&v), (en & ~(&v)) ? v + 1'b1 : v};
  endfunction

  // Edge detects sit one register past the synchronisers, giving equal latency on both inputs.
  assign rise0  = s0_q[SYNC_STAGES-1] & ~e0_q;
  assign rise1  = s1_q[SYNC_STAGES-1] & ~e1_q;
  assign to_hit = (to_q == TW'(TIMEOUT_CYCLES - 1)) && !rise0;
  assign clear  = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    s0_d    = {s0_q[SYNC_STAGES-2:0], sig_in};
    s1_d    = {s1_q[SYNC_STAGES-2:0], sig_in1};
    e0_d    = s0_q[SYNC_STAGES-1];
    e1_d    = s1_q[SYNC_STAGES-1];
    to_d    = to_q;
    ecnt_d  = ecnt_q;
    run_d   = run_q;
    miss_d  = miss_q;
    win     = 1'b0;
    tmo     = 1'b0;
    rper_d  = rper_q;
    rhigh_d = rhigh_q;
    rph_d   = rph_q;
    rtmo_d  = rtmo_q;
    rovf_d  = rovf_q;
    rmiss_d = rmiss_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          to_d    = '0;
          run_d   = 1'b0;
          miss_d  = 1'b0;
        end
      end
      ARM: begin
        to_d = rise0 ? '0 : to_q + 1'b1;
        if (rise0) begin
          state_d = MEAS;
          win     = 1'b1;
          ecnt_d  = '0;
        end else if (to_hit) begin
          state_d = DONE;
          tmo     = 1'b1;
        end
      end
      MEAS: begin
        to_d = rise0 ? '0 : to_q + 1'b1;
        if (rise0 && ecnt_q == EW'(GATE_PERIODS - 1)) begin
          state_d = DONE;
        end else begin
          win = 1'b1;
          if (rise0) ecnt_d = ecnt_q + 1'b1;
          if (to_hit) begin
            state_d = DONE;
            tmo     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q == ARM || state_q == MEAS) begin
      run_d  = rise1 ? 1'b0 : (rise0 && win) ? 1'b1 : run_q;
      miss_d = miss_q | (rise0 & run_q & ~rise1);
    end
    {op, per_n}   = sat_inc(per_q, win);
    {oh, high_n}  = sat_inc(high_q, win & s0_q[SYNC_STAGES-1]);
    {oph, ph_n}   = sat_inc(ph_q, win & run_d);
    per_d  = clear ? '0 : per_n;
    high_d = clear ? '0 : high_n;
    ph_d   = clear ? '0 : ph_n;
    ovf_d  = clear ? 1'b0 : (ovf_q | op | oh | oph);
    if (state_d == DONE && state_q != DONE) begin
      rper_d  = tmo ? '0 : per_q;
      rhigh_d = tmo ? '0 : high_q;
      rph_d   = tmo ? '0 : ph_q;
      rtmo_d  = tmo;
      rovf_d  = !tmo && ovf_q;
      rmiss_d = !tmo && miss_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s0_q    <= '0;
      s1_q    <= '0;
      e0_q    <= 1'b0;
      e1_q    <= 1'b0;
      to_q    <= '0;
      ecnt_q  <= '0;
      run_q   <= 1'b0;
      miss_q  <= 1'b0;
      ovf_q   <= 1'b0;
      per_q   <= '0;
      high_q  <= '0;
      ph_q    <= '0;
      rper_q  <= '0;
      rhigh_q <= '0;
      rph_q   <= '0;
      rtmo_q  <= 1'b0;
      rovf_q  <= 1'b0;
      rmiss_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      to_q    <= to_d;
      ecnt_q  <= ecnt_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      ovf_q   <= ovf_d;
      per_q   <= per_d;
      high_q  <= high_d;
      ph_q    <= ph_d;
      rper_q  <= rper_d;
      rhigh_q <= rhigh_d;
      rph_q   <= rph_d;
      rtmo_q  <= rtmo_d;
      rovf_q  <= rovf_d;
      rmiss_q <= rmiss_d;
    end
  end

  assign busy       = (state_q == ARM) || (state_q == MEAS);
  assign done       = (state_q == DONE);
  assign timeout    = rtmo_q;
  assign ovf        = rovf_q;
  assign phase_miss = rmiss_q;
  assign period_cnt = rper_q;
  assign high_cnt   = rhigh_q;
  assign phase_cnt  = rph_q;
endmodule

// File: tb/tb_freq_phase_meter.sv
// tb_freq_phase_meter: directed and randomised measurements of two meter instances (32-bit and 4-bit results).
module tb_freq_phase_meter;
  localparam int GP = 4;

  logic clk = 0, rst_n = 0, sig_in = 0, sig_in1 = 0, start = 0;
  logic a_busy, a_done, a_timeout, a_ovf, a_miss;
  logic [31:0] a_per, a_high, a_ph;
  logic b_busy, b_done, b_timeout, b_ovf, b_miss;
  logic [3:0] b_per, b_high, b_ph;
  int vectors = 0, errors = 0;
  int ph = 0;

  always #10 clk = ~clk;

  freq_phase_meter #(.CNT_W(32), .GATE_PERIODS(GP), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .sig_in1(sig_in1), .start(start),
    .busy(a_busy), .done(a_done), .timeout(a_timeout), .ovf(a_ovf), .phase_miss(a_miss),
    .period_cnt(a_per), .high_cnt(a_high), .phase_cnt(a_ph));

  freq_phase_meter #(.CNT_W(4), .GATE_PERIODS(GP), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1000)) dut4 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .sig_in1(sig_in1), .start(start),
    .busy(b_busy), .done(b_done), .timeout(b_timeout), .ovf(b_ovf), .phase_miss(b_miss),
    .period_cnt(b_per), .high_cnt(b_high), .phase_cnt(b_ph));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: sig_in1 is sig_in delayed d cycles; mode 1: sig_in1 held high
  task automatic step(input int p, input int h, input int d, input int mode);
    @(negedge clk);
    ph = (ph + 1) % p;
    sig_in  = ph < h;
    sig_in1 = (mode == 1) ? 1'b1 : (((ph - d + p) % p) < h);
  endtask

  function automatic int sat4(input int v);
    return v > 15 ? 15 : v;
  endfunction

  task automatic measure(input string tag, input int p, input int h, input int d, input int mode, input bit poke);
    int nd = 0, nd4 = 0;
    int e_per, e_high, e_ph;
    logic [31:0] c_per = 0, c_high = 0, c_ph = 0;
    logic c_tmo = 0, c_ovf = 0, c_miss = 0, c4_ovf = 0;
    logic [3:0] c4_per = 0, c4_high = 0, c4_ph = 0;
    repeat (2 * p) step(p, h, d, mode);
    start = 1;
    step(p, h, d, mode);
    start = 0;
    for (int i = 0; i < 110; i++) begin
      step(p, h, d, mode);
      if (a_done) begin
        nd++;
        c_per = a_per; c_high = a_high; c_ph = a_ph;
        c_tmo = a_timeout; c_ovf = a_ovf; c_miss = a_miss;
      end
      if (b_done) begin
        nd4++;
        c4_per = b_per; c4_high = b_high; c4_ph = b_ph; c4_ovf = b_ovf;
      end
      start = poke && a_busy && (i % 5 == 0);
    end
    start = 0;
    e_per  = GP * p;
    e_high = GP * h;
    e_ph   = (mode == 1) ? GP * p : GP * d;
    chk({tag, ".done_count"}, nd, 1);
    chk({tag, ".done_count4"}, nd4, 1);
    chk({tag, ".period_cnt"}, c_per, e_per);
    chk({tag, ".high_cnt"}, c_high, e_high);
    chk({tag, ".phase_cnt"}, c_ph, e_ph);
    chk({tag, ".timeout"}, c_tmo, 0);
    chk({tag, ".ovf"}, c_ovf, 0);
    chk({tag, ".phase_miss"}, c_miss, (mode == 1) ? 1 : 0);
    chk({tag, ".period_cnt4"}, c4_per, sat4(e_per));
    chk({tag, ".high_cnt4"}, c4_high, sat4(e_high));
    chk({tag, ".phase_cnt4"}, c4_ph, sat4(e_ph));
    chk({tag, ".ovf4"}, c4_ovf, (e_per > 15 || e_high > 15 || e_ph > 15) ? 1 : 0);
  endtask

  initial begin
    int cyc, nd, p, h, d;
    repeat (3) @(negedge clk);
    chk("reset.busy", a_busy, 0);
    chk("reset.done", a_done, 0);
    chk("reset.period_cnt", a_per, 0);
    chk("reset.timeout", a_timeout, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    measure("case1", 8, 3, 2, 0, 0);
    measure("aligned", 8, 3, 0, 0, 0);
    measure("sig1_high", 8, 3, 0, 1, 0);

    sig_in = 0;
    sig_in1 = 0;
    repeat (10) @(negedge clk);
    cyc = -1;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 1; i <= 1100; i++) begin
      if (a_done) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
    chk("timeout.arm_to_done", cyc, 1001);
    chk("timeout.flag", a_timeout, 1);
    chk("timeout.flag4", b_timeout, 1);
    chk("timeout.period_cnt", a_per, 0);
    chk("timeout.high_cnt", a_high, 0);
    chk("timeout.phase_cnt", a_ph, 0);
    chk("timeout.ovf4", b_ovf, 0);
    chk("timeout.phase_miss", a_miss, 0);

    measure("pre_reset", 8, 3, 2, 0, 0);
    nd = 0;
    repeat (16) step(8, 3, 2, 0);
    start = 1;
    step(8, 3, 2, 0);
    start = 0;
    for (int i = 0; i < 20; i++) begin
      step(8, 3, 2, 0);
      if (a_done) nd++;
    end
    chk("abort.busy_before", a_busy, 1);
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      step(8, 3, 2, 0);
      if (a_done) nd++;
    end
    chk("abort.done_count", nd, 0);
    chk("abort.busy", a_busy, 0);
    chk("abort.period_cnt", a_per, 0);
    rst_n = 1;
    measure("rerun_poke", 8, 3, 2, 0, 1);

    for (int k = 0; k < 5; k++) begin
      p = $urandom_range(12, 4);
      h = $urandom_range(p - 1, 1);
      d = $urandom_range(p - 1, 0);
      measure($sformatf("rand%0d_p%0d_h%0d_d%0d", k, p, h, d), p, h, d, (k == 4) ? 1 : 0, k[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
